// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: handshake states and the
// fixed-priority selector (lowest index wins).
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_e;

  localparam int unsigned PRIO_W = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } prio_t;

  function automatic prio_t prio_sel(input logic [PRIO_W-1:0] pending_masked);
    prio_t sel;
    sel = '0;
    for (int unsigned i = 0; i < PRIO_W; i++) begin
      if (pending_masked[i] && !sel.valid) begin
        sel.valid = 1'b1;
        sel.idx   = 5'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_controller_capture.sv
// Per-channel request capture: rising-edge or level detect into latched
// pending bits that clear only on their own acknowledge.
module irq_controller_capture #(
  parameter int unsigned          NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0]   EDGE_MODE = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] clr_i,
  output logic [NUM_IRQ-1:0] pending_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] set;

  always_comb begin
    set       = (EDGE_MODE & irq_i & ~irq_q) | (~EDGE_MODE & irq_i);
    // set is applied after clear so an event coinciding with its ack survives
    pending_d = (pending_q & ~clr_i) | set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: NMI plus NUM_IRQ maskable channels, fixed priority,
// registered vector and a request/acknowledge/EOI handshake with the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned        NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MODE = '1,
  parameter logic [NUM_IRQ-1:0] MASK_RST  = '1,
  parameter int unsigned        VEC_W     = $clog2(NUM_IRQ + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi,
  input  logic               int_disable,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               cpu_ina,
  input  logic               eoi,
  output logic               cpu_int,
  output logic [VEC_W-1:0]   vector,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  localparam logic [VEC_W-1:0] NMI_VEC = VEC_W'(NUM_IRQ);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic               cpu_int_q, cpu_int_d;
  logic               in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               nmi_q;
  logic               nmi_pending_q, nmi_pending_d;
  logic [NUM_IRQ-1:0] pending_w;
  logic [NUM_IRQ-1:0] clr;
  logic               ack;
  prio_t              sel;

  irq_controller_capture #(
    .NUM_IRQ  (NUM_IRQ),
    .EDGE_MODE(EDGE_MODE)
  ) u_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_i    (irq),
    .clr_i    (clr),
    .pending_o(pending_w)
  );

  always_comb sel = prio_sel(PRIO_W'(pending_w & ~mask_q));

  always_comb begin
    state_d      = state_q;
    vector_d     = vector_q;
    cpu_int_d    = cpu_int_q;
    in_service_d = in_service_q;
    ack          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (nmi_pending_q) begin
          vector_d  = NMI_VEC;
          cpu_int_d = 1'b1;
          state_d   = REQ;
        end else if (sel.valid && !int_disable) begin
          vector_d  = VEC_W'(sel.idx);
          cpu_int_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (cpu_ina) begin
          ack          = 1'b1;
          cpu_int_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      clr[i] = ack && (vector_q == VEC_W'(i));
    end
    nmi_pending_d = (nmi_pending_q & ~(ack && (vector_q == NMI_VEC))) | (nmi & ~nmi_q);
    mask_d        = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vector_q      <= '0;
      cpu_int_q     <= 1'b0;
      in_service_q  <= 1'b0;
      mask_q        <= MASK_RST;
      nmi_q         <= 1'b0;
      nmi_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      vector_q      <= vector_d;
      cpu_int_q     <= cpu_int_d;
      in_service_q  <= in_service_d;
      mask_q        <= mask_d;
      nmi_q         <= nmi;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign cpu_int    = cpu_int_q;
  assign vector     = vector_q;
  assign in_service = in_service_q;
  assign pending    = pending_w;
  assign mask       = mask_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt controller between N peripheral request lines and the multi-cycle CPU's interrupt inputs.
- Replaces the single INT/NMI/INTD wiring with:
  - per-channel pending and mask state
  - per-channel edge/level mode
  - fixed priority
  - a registered vector
  - a request/acknowledge/end-of-interrupt handshake with the CPU's acknowledge (INA) output.
- One interrupt is in service at a time; NMI outranks all maskable channels.

Parameters:
- NUM_IRQ, 8: number of maskable request channels (2..32).
- EDGE_MODE, 8'hFF: bit i = 1 makes channel i edge-triggered (rising); 0 makes it level-triggered. Width is NUM_IRQ.
- MASK_RST, 8'hFF: reset value of the mask register (1 = masked). Width is NUM_IRQ.
- VEC_W, $clog2(NUM_IRQ+1): vector width. Vector value NUM_IRQ identifies NMI.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- irq  in  NUM_IRQ  peripheral requests, already synchronous to clk
- nmi  in  1  non-maskable request, rising-edge detected
- int_disable  in  1  CPU INTD; blocks maskable requests from being raised
- mask_we  in  1  mask register write strobe
- mask_wdata  in  NUM_IRQ  new mask value
- cpu_ina  in  1  CPU acknowledge pulse
- eoi  in  1  end-of-interrupt pulse from the handler
- cpu_int  out  1  interrupt request to the CPU
- vector  out  VEC_W  id of the requested or in-service source
- in_service  out  1  a handler is active (acknowledged, EOI not yet seen)
- pending  out  NUM_IRQ  pending bits, for status readback
- mask  out  NUM_IRQ  current mask register

Behaviour:
Reset:
- Asserting rst_n low immediately forces: state IDLE, cpu_int=0, vector=0, in_service=0, pending=0, nmi_pending=0, mask=MASK_RST, edge-detect history=0.
- Reset mid-handshake abandons the handshake; nothing is retained.

Capture, every cycle:
- Edge channel: pending[i] is set when irq[i]=1 and it was 0 in the previous cycle.
- Level channel: pending[i] is set whenever irq[i]=1.
- Pending bits are latched. They clear only when their own acknowledge is taken, never on line deassertion.
- If set and clear hit the same bit in the same cycle, set wins: the new event is kept.
- nmi_pending uses the same rule on a nmi rising edge.
- Masking affects selection only. Masked channels still accumulate pending.

Mask register:
- mask_we loads mask_wdata on the next edge.
- The new mask takes effect for selection in the following cycle.

Selection (combinational, used in IDLE only):
- NMI has top priority.
- Otherwise the lowest index i with pending[i] & ~mask[i].
- Maskable candidates are ignored while int_disable=1. NMI ignores int_disable.

FSM:
- IDLE
  - If a candidate exists: vector <= selected id, cpu_int <= 1, go to REQ.
- REQ
  - vector is frozen; there is no preemption, not even by NMI.
  - Changes to int_disable or mask do not withdraw the request.
  - On cpu_ina=1: clear the selected pending bit (or nmi_pending), cpu_int <= 0, in_service <= 1, go to SERVICE.
- SERVICE
  - vector is held.
  - On eoi=1: in_service <= 0, go to IDLE.
  - A new request can be raised from the next cycle.
- Handshake inputs out of context:
  - cpu_ina outside REQ is ignored.
  - eoi outside SERVICE is ignored.
  - cpu_ina and eoi asserted together in REQ: only the acknowledge is taken.

Latency:
- Edge event on irq in cycle t: pending visible after edge t+1, cpu_int high after edge t+2.
- EOI in cycle t returns to IDLE at edge t+1. The next cpu_int rises at edge t+2 at the earliest.

Level re-request:
- If a level line is still high after acknowledge, pending re-sets on the next cycle.
- The channel is re-requested after EOI.

Decomposition:
- Package irq_pkg holds:
  - state enum (IDLE, REQ, SERVICE)
  - function prio_sel(pending_masked) -> index and valid
- Optional sub-module irq_capture: per-channel edge/level detect and pending set/clear. The FSM and registers stay in irq_controller.

Test Plan:
All scenarios use NUM_IRQ=8, EDGE_MODE=8'h0F, MASK_RST=8'h00.
- After reset release: outputs cpu_int=0, vector=0, mask=0, pending=0.
- irq[2] one-cycle pulse at t, edge mode:
  - pending=8'h04 at t+1; cpu_int=1, vector=2 at t+2.
  - cpu_ina -> pending=0, in_service=1.
  - eoi -> IDLE.
- irq[5] and irq[1] rise together:
  - vector=1 served first.
  - After eoi, vector=5 is requested two cycles later.
- Level irq[6] held high through ack and eoi: re-pending after ack; second request with vector=6 after EOI.
- Priority and preemption:
  - mask=8'h01 with irq[0] pending: no cpu_int.
  - int_disable=1 with irq[3] pending: no cpu_int.
  - nmi edge under int_disable: vector=8.
  - nmi arriving while in REQ for channel 3: vector stays 3, NMI served next.
- Reset mid-operation: rst_n low during SERVICE -> outputs clear immediately; mask returns to 8'h00.
- Out-of-context pulses: eoi in IDLE and cpu_ina in SERVICE produce no state change.
